// File: rtl/idex_stall_reg.sv
`default_nettype none
// ============================================================================
// Module   : idex_stall_reg
// Purpose  : ID/EX pipeline register with stall/flush bubbles, freeze hold,
//            PC/IF-ID write enables, a stall counter and a stall watchdog.
// Revision : 1.0
// ============================================================================
module idex_stall_reg #(
    parameter int DW        = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             freeze,
    input  logic [DW-1:0]    id_pc,
    input  logic [DW-1:0]    id_rs_data,
    input  logic [DW-1:0]    id_rt_data,
    input  logic [DW-1:0]    id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [8:0]       id_ctrl,
    output logic [DW-1:0]    ex_pc,
    output logic [DW-1:0]    ex_rs_data,
    output logic [DW-1:0]    ex_rt_data,
    output logic [DW-1:0]    ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [8:0]       ex_ctrl,
    output logic             ex_memread,
    output logic             ex_valid,
    output logic             pc_write,
    output logic             ifid_write,
    output logic [CNT_W-1:0] stall_count,
    output logic             stall_err
);

    // Run counter only needs to reach MAX_STALL+1 to detect an overrun.
    localparam int RUN_W = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] c_RUN_MAX   = RUN_W'(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] c_RUN_LIMIT = RUN_W'(MAX_STALL);

    logic [DW-1:0]    r_pc, r_rs_data, r_rt_data, r_imm;
    logic [4:0]       r_rs, r_rt, r_rd;
    logic [8:0]       r_ctrl;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_count;
    logic             r_stall_err;
    logic [RUN_W-1:0] r_run;

    logic             w_bubble;
    logic [RUN_W-1:0] w_run_inc;
    logic [CNT_W-1:0] w_cnt_inc;

    always_comb begin
        w_bubble  = flush | stall;
        w_run_inc = (r_run == c_RUN_MAX) ? r_run : r_run + RUN_W'(1);
        w_cnt_inc = (&r_stall_count) ? r_stall_count : r_stall_count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= '0;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_imm         <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
            r_ctrl        <= '0;
            r_valid       <= 1'b0;
            r_stall_count <= '0;
            r_stall_err   <= 1'b0;
            r_run         <= '0;
        end else if (!freeze) begin
            if (w_bubble) begin
                // Zeroed bubble keeps ex_memread low so the hazard unit never re-stalls on it.
                r_pc      <= '0;
                r_rs_data <= '0;
                r_rt_data <= '0;
                r_imm     <= '0;
                r_rs      <= '0;
                r_rt      <= '0;
                r_rd      <= '0;
                r_ctrl    <= '0;
                r_valid   <= 1'b0;
            end else begin
                r_pc      <= id_pc;
                r_rs_data <= id_rs_data;
                r_rt_data <= id_rt_data;
                r_imm     <= id_imm;
                r_rs      <= id_rs;
                r_rt      <= id_rt;
                r_rd      <= id_rd;
                r_ctrl    <= id_ctrl;
                r_valid   <= 1'b1;
            end

            if (stall && !flush) begin
                r_stall_count <= w_cnt_inc;
                r_run         <= w_run_inc;
                if (w_run_inc > c_RUN_LIMIT)
                    r_stall_err <= 1'b1;
            end else begin
                r_run <= '0;
            end
        end
    end

    assign pc_write    = ~freeze & (flush | ~stall);
    assign ifid_write  = pc_write;

    assign ex_pc       = r_pc;
    assign ex_rs_data  = r_rs_data;
    assign ex_rt_data  = r_rt_data;
    assign ex_imm      = r_imm;
    assign ex_rs       = r_rs;
    assign ex_rt       = r_rt;
    assign ex_rd       = r_rd;
    assign ex_ctrl     = r_ctrl;
    assign ex_memread  = r_ctrl[7];
    assign ex_valid    = r_valid;
    assign stall_count = r_stall_count;
    assign stall_err   = r_stall_err;

endmodule
`default_nettype wire

// File: tb/tb_idex_stall_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_idex_stall_reg
// Purpose  : Directed self-checking bench for idex_stall_reg (CNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_idex_stall_reg;

    localparam int DW        = 32;
    localparam int CNT_W     = 4;
    localparam int MAX_STALL = 4;

    logic             clk = 1'b0;
    logic             reset, stall, flush, freeze;
    logic [DW-1:0]    id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]       id_rs, id_rt, id_rd;
    logic [8:0]       id_ctrl;
    logic [DW-1:0]    ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]       ex_rs, ex_rt, ex_rd;
    logic [8:0]       ex_ctrl;
    logic             ex_memread, ex_valid, pc_write, ifid_write, stall_err;
    logic [CNT_W-1:0] stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    idex_stall_reg #(.DW(DW), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .freeze(freeze),
        .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_ctrl(id_ctrl), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_memread(ex_memread),
        .ex_valid(ex_valid), .pc_write(pc_write), .ifid_write(ifid_write),
        .stall_count(stall_count), .stall_err(stall_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rt, input logic [8:0] ctrl);
        id_pc      = pc;
        id_rs_data = pc + 32'h100;
        id_rt_data = pc + 32'h200;
        id_imm     = pc + 32'h300;
        id_rs      = 5'd3;
        id_rt      = rt;
        id_rd      = 5'd7;
        id_ctrl    = ctrl;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc"},    ex_pc, 32'h0);
        chk({tag, "_rsd"},   ex_rs_data, 32'h0);
        chk({tag, "_imm"},   ex_imm, 32'h0);
        chk({tag, "_rt"},    32'(ex_rt), 32'h0);
        chk({tag, "_ctrl"},  32'(ex_ctrl), 32'h0);
        chk({tag, "_valid"}, 32'(ex_valid), 32'h0);
        chk({tag, "_cnt"},   32'(stall_count), 32'h0);
        chk({tag, "_err"},   32'(stall_err), 32'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; freeze = 1'b0;
        set_id(32'h0, 5'd0, 9'h0);
        step(); step();
        chk_all_zero("rst");
        reset = 1'b0;

        // Normal load
        set_id(32'h10, 5'd5, 9'h1C0);
        #1 chk("norm_pcw", 32'(pc_write), 32'd1);
        step();
        chk("norm_pc",    ex_pc, 32'h10);
        chk("norm_rtd",   ex_rt_data, 32'h210);
        chk("norm_rt",    32'(ex_rt), 32'd5);
        chk("norm_rd",    32'(ex_rd), 32'd7);
        chk("norm_ctrl",  32'(ex_ctrl), 32'h1C0);
        chk("norm_mr",    32'(ex_memread), 32'd1);
        chk("norm_valid", 32'(ex_valid), 32'd1);

        // Single stall
        stall = 1'b1;
        #1;
        chk("st_pcw",  32'(pc_write), 32'd0);
        chk("st_ifid", 32'(ifid_write), 32'd0);
        step();
        chk("st_ctrl",  32'(ex_ctrl), 32'h0);
        chk("st_rt",    32'(ex_rt), 32'h0);
        chk("st_mr",    32'(ex_memread), 32'd0);
        chk("st_valid", 32'(ex_valid), 32'd0);
        chk("st_cnt",   32'(stall_count), 32'd1);

        // Flush beats stall
        flush = 1'b1;
        #1 chk("fl_pcw", 32'(pc_write), 32'd1);
        chk("fl_ifid", 32'(ifid_write), 32'd1);
        step();
        chk("fl_valid", 32'(ex_valid), 32'd0);
        chk("fl_ctrl",  32'(ex_ctrl), 32'h0);
        chk("fl_cnt",   32'(stall_count), 32'd1);
        flush = 1'b0; stall = 1'b0;

        set_id(32'h20, 5'd9, 9'h181);
        step();
        chk("n2_pc", ex_pc, 32'h20);

        // Freeze with stall held and changing ID fields
        freeze = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(32'h40 + 32'(i), 5'(i + 11), 9'h0AA);
            #1 chk("fz_pcw", 32'(pc_write), 32'd0);
            step();
            chk("fz_pc",    ex_pc, 32'h20);
            chk("fz_rt",    32'(ex_rt), 32'd9);
            chk("fz_ctrl",  32'(ex_ctrl), 32'h181);
            chk("fz_valid", 32'(ex_valid), 32'd1);
            chk("fz_cnt",   32'(stall_count), 32'd1);
        end
        freeze = 1'b0;

        // Five consecutive stalls trip the watchdog on the fifth edge
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("wd_cnt", 32'(stall_count), 32'(1 + i));
            chk("wd_err", 32'(stall_err), (i == 5) ? 32'd1 : 32'd0);
        end
        stall = 1'b0;
        step();
        chk("wd_sticky", 32'(stall_err), 32'd1);
        chk("wd_valid",  32'(ex_valid), 32'd1);
        chk("wd_pc",     ex_pc, 32'h42);

        // Saturation: 16 isolated stalls from a clean counter
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("sat_rst_err", 32'(stall_err), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            stall = 1'b1;
            step();
            stall = 1'b0;
            chk("sat_cnt", 32'(stall_count), (i > 15) ? 32'd15 : 32'(i));
            step();
        end
        chk("sat_err", 32'(stall_err), 32'd0);

        // Reset asserted mid-stall
        stall = 1'b1; reset = 1'b1;
        step();
        chk_all_zero("rst_mid");
        reset = 1'b0; stall = 1'b0;
        set_id(32'h80, 5'd2, 9'h1C0);
        #1 chk("post_pcw", 32'(pc_write), 32'd1);
        step();
        chk("post_pc",    ex_pc, 32'h80);
        chk("post_valid", 32'(ex_valid), 32'd1);
        chk("post_cnt",   32'(stall_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
